// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) with a
// start/done handshake. It feeds per-digit 7-segment decoders.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]   scratch, scratch_n;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bcd_n;
  logic            done_n;

  // Add-3 is applied per nibble, so no carry ever crosses a digit boundary.
  always_comb begin
    adj = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    scratch_n = scratch;
    cnt_n     = cnt;
    bcd_n     = bcd_out;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n   = bin_in;
          scratch_n = '0;
          cnt_n     = CW'(WIDTH);
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_n, shreg_n} = {adj, shreg} << 1;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // done and bcd_out are registered, so they appear together as the FSM returns to IDLE.
        bcd_n   = scratch;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      scratch <= scratch_n;
      cnt     <= cnt_n;
      bcd_out <= bcd_n;
      done    <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=9, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion, count edges (accepting edge = 1) until done, then check.
  task automatic test_convert(input logic [8:0] v, input logic [11:0] expv, input string name);
    int k;
    bin_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = ~v;
    k = 1;
    while (!done && k <= 30) begin
      tick();
      k++;
    end
    checks++;
    if (k !== 11) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, expected 11", name, k);
    end
    checks++;
    if (bcd_out !== expv) begin
      errors++;
      $display("FAIL %s_value: got %h, expected %h", name, bcd_out, expv);
    end
    tick();
    checks++;
    if (done !== 1'b0 || bcd_out !== expv) begin
      errors++;
      $display("FAIL %s_hold: got done=%b bcd=%h, expected done=0 bcd=%h", name, done, bcd_out, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (bcd_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got bcd=%h busy=%b done=%b, expected 000 0 0", bcd_out, busy, done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bcd_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got bcd=%h busy=%b done=%b, expected 000 0 0", i, bcd_out, busy, done);
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone;
    int done_k;
    bit busy_ok;
    ndone = 0; done_k = 0; busy_ok = 1'b1;
    bin_in = 9'd37;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 2; k <= 30; k++) begin
      if (k == 5) begin
        bin_in = 9'd400;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (done_k == 0) done_k = k;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (done_k == 0 && busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignored_start_count: got %0d done pulses, expected 1", ndone);
    end
    checks++;
    if (done_k !== 11) begin
      errors++;
      $display("FAIL ignored_start_latency: got %0d, expected 11", done_k);
    end
    checks++;
    if (bcd_out !== 12'h037) begin
      errors++;
      $display("FAIL ignored_start_value: got %h, expected 037", bcd_out);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_busy: got busy profile bad, expected high until done");
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    bin_in = 9'd123;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got done=%b busy=%b bcd=%h, expected 0 0 000", done, busy, bcd_out);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses, expected 0", ndone);
    end
    rst = 1'b1; start = 1'b1; bin_in = 9'd200;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_and_start: got busy=%b, expected 0", busy);
    end
    test_convert(9'd123, 12'h123, "after_reset");
  endtask

  task automatic test_back_to_back();
    int k;
    logic [11:0] expv;
    bin_in = 9'd0;
    start  = 1'b1;
    for (int v = 0; v < 512; v++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!done && k <= 30);
      bin_in = 9'(v + 1);
      expv = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      checks++;
      if (k !== 11) begin
        errors++;
        $display("FAIL sweep_interval_%0d: got %0d, expected 11", v, k);
      end
      checks++;
      if (bcd_out !== expv) begin
        errors++;
        $display("FAIL sweep_value_%0d: got %h, expected %h", v, bcd_out, expv);
      end
    end
    start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0;
    test_reset();
    test_convert(9'd9,   12'h009, "conv_9");
    test_convert(9'd0,   12'h000, "conv_0");
    test_convert(9'd511, 12'h511, "conv_max");
    test_convert(9'd255, 12'h255, "conv_255");
    test_convert(9'd100, 12'h100, "conv_100");
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
